// File: rtl/pdp8_ifetch_if.sv
// Fetch-unit bus bundle: memory read port, execute-unit handshake and the
// start/busy control pair. The fetch unit is the master, the environment the slave.
interface pdp8_ifetch_if;
  logic        start;
  logic        ifu_rd_req;
  logic [11:0] ifu_rd_addr;
  logic [11:0] ifu_rd_data;
  logic        instr_valid;
  logic        exec_ready;
  logic [11:0] instr_word;
  logic [2:0]  instr_opcode;
  logic [11:0] instr_ea;
  logic [11:0] instr_pc;
  logic        exec_pc_load;
  logic [11:0] exec_new_pc;
  logic        exec_halt;
  logic        fetch_busy;

  modport master (
    input  start, ifu_rd_data, exec_ready, exec_pc_load, exec_new_pc, exec_halt,
    output ifu_rd_req, ifu_rd_addr, instr_valid, instr_word, instr_opcode,
           instr_ea, instr_pc, fetch_busy
  );

  modport slave (
    output start, ifu_rd_data, exec_ready, exec_pc_load, exec_new_pc, exec_halt,
    input  ifu_rd_req, ifu_rd_addr, instr_valid, instr_word, instr_opcode,
           instr_ea, instr_pc, fetch_busy
  );
endinterface

// File: rtl/pdp8_ifetch.sv
// PDP-8 instruction fetch/decode front end. Owns the PC, fetches one word per
// instruction, resolves page/zero-page effective addresses with at most one
// level of indirection, and presents the result to the execute unit.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | stopped, waiting for start
// S_FETCH    | instruction read request issued at PC, PC advances
// S_WAIT     | counting read latency, decode on the capture cycle
// S_IND_RD   | pointer read request issued at the decoded address
// S_IND_WAIT | counting read latency, pointer becomes the effective address
// S_DISPATCH | instruction offered to execute unit until handshake
module pdp8_ifetch #(
  parameter logic [11:0] START_ADDR = 12'o0200,
  parameter int          RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  pdp8_ifetch_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_IND_RD, S_IND_WAIT, S_DISPATCH
  } state_t;

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  state_t      state, state_nxt;
  logic [11:0] pc;
  logic [11:0] ptr_addr;
  logic [2:0]  lat_cnt;
  logic [11:0] word_q;
  logic [2:0]  op_q;
  logic [11:0] ea_q;
  logic [11:0] ipc_q;

  logic        lat_done;
  logic        handshake;
  logic        dec_mem;
  logic        dec_ind;
  logic [11:0] dec_base;
  logic [11:0] dec_ea;

  assign lat_done  = (lat_cnt == LAT);
  assign handshake = (state == S_DISPATCH) && bus.exec_ready;

  // Decode straight off the read data; only consumed in the capture cycle.
  // Opcodes 6 and 7 (IOT/OPR) carry no memory operand.
  assign dec_mem  = (bus.ifu_rd_data[11:9] < 3'd6);
  assign dec_ind  = dec_mem && bus.ifu_rd_data[8];
  assign dec_base = bus.ifu_rd_data[7] ? {ipc_q[11:7], 7'b0} : 12'b0;
  assign dec_ea   = dec_base | {5'b0, bus.ifu_rd_data[6:0]};

  assign bus.instr_word   = word_q;
  assign bus.instr_opcode = op_q;
  assign bus.instr_ea     = ea_q;
  assign bus.instr_pc     = ipc_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt       = state;
    bus.ifu_rd_req  = 1'b0;
    bus.ifu_rd_addr = 12'b0;
    bus.instr_valid = 1'b0;
    bus.fetch_busy  = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        bus.ifu_rd_req  = 1'b1;
        bus.ifu_rd_addr = pc;
        state_nxt       = S_WAIT;
      end
      S_WAIT: begin
        if (lat_done) state_nxt = dec_ind ? S_IND_RD : S_DISPATCH;
      end
      S_IND_RD: begin
        bus.ifu_rd_req  = 1'b1;
        bus.ifu_rd_addr = ptr_addr;
        state_nxt       = S_IND_WAIT;
      end
      S_IND_WAIT: begin
        if (lat_done) state_nxt = S_DISPATCH;
      end
      S_DISPATCH: begin
        bus.instr_valid = 1'b1;
        if (handshake) state_nxt = bus.exec_halt ? S_IDLE : S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // PC, latency counter and captured instruction fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= START_ADDR;
      ptr_addr <= 12'b0;
      lat_cnt  <= 3'd0;
      word_q   <= 12'b0;
      op_q     <= 3'd0;
      ea_q     <= 12'b0;
      ipc_q    <= 12'b0;
    end else begin
      case (state)
        S_IDLE: begin
          lat_cnt <= 3'd0;
          if (bus.start) pc <= START_ADDR;
        end
        S_FETCH: begin
          ipc_q   <= pc;
          pc      <= pc + 12'd1;
          lat_cnt <= 3'd1;
        end
        S_WAIT: begin
          if (lat_done) begin
            word_q <= bus.ifu_rd_data;
            op_q   <= bus.ifu_rd_data[11:9];
            if (dec_ind)      ptr_addr <= dec_ea;
            else if (dec_mem) ea_q     <= dec_ea;
            else              ea_q     <= 12'b0;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        S_IND_RD: begin
          lat_cnt <= 3'd1;
        end
        S_IND_WAIT: begin
          if (lat_done) ea_q    <= bus.ifu_rd_data;
          else          lat_cnt <= lat_cnt + 3'd1;
        end
        S_DISPATCH: begin
          if (handshake && !bus.exec_halt && bus.exec_pc_load) pc <= bus.exec_new_pc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pdp8_ifetch.sv
// Directed bench for pdp8_ifetch: a small memory responder serves each read,
// the expected dispatch (word/opcode/ea/pc/latency) is queued when the read is
// served and compared when instr_valid appears.
module tb_pdp8_ifetch;
  localparam int RDL = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pdp8_ifetch_if bus();

  pdp8_ifetch #(.START_ADDR(12'o0200), .RD_LATENCY(RDL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] word;
    logic [2:0]  op;
    logic [11:0] ea;
    logic [11:0] pc;
    int          lat;
    int          req_cyc;
  } exp_t;

  exp_t sb[$];
  bit   chk_follow = 1'b0;
  int   follow_cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_ea(input logic [11:0] w, input logic [11:0] pc);
    logic [11:0] base;
    base = w[7] ? {pc[11:7], 7'b0} : 12'o0;
    if (w[11:9] >= 3'd6) return 12'o0;
    return base | {5'b0, w[6:0]};
  endfunction

  function automatic logic [63:0] all_outs();
    return {10'b0, bus.ifu_rd_req, bus.ifu_rd_addr, bus.instr_valid, bus.instr_word,
            bus.instr_opcode, bus.instr_ea, bus.instr_pc, bus.fetch_busy};
  endfunction

  task automatic wait_req(output logic [11:0] addr, output int rc);
    bit ok = 1'b0;
    int seen_valid = 0;
    addr = 12'o0;
    rc   = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.instr_valid) seen_valid++;
      if (bus.ifu_rd_req) begin
        ok   = 1'b1;
        addr = bus.ifu_rd_addr;
        rc   = cyc;
        break;
      end
    end
    check("req_seen", ok, 1);
    check("no_valid_before_req", seen_valid, 0);
  endtask

  // Garbage everywhere except the capture cycle so stray sampling shows up.
  task automatic serve(input logic [11:0] data);
    bus.ifu_rd_data = 12'o5555;
    repeat (RDL) begin
      @(posedge clk);
      #1;
      check("no_back2back_req", bus.ifu_rd_req, 0);
    end
    bus.ifu_rd_data = data;
    @(posedge clk);
    #1 bus.ifu_rd_data = 12'o2525;
  endtask

  task automatic fetch_instr(input logic [11:0] exp_addr, input logic [11:0] word,
                             input logic [11:0] ptr_data);
    logic [11:0] a;
    int rc, rc2;
    exp_t e;
    wait_req(a, rc);
    check("fetch_addr", a, exp_addr);
    if (chk_follow) check("req_follows", rc, follow_cyc + 1);
    chk_follow = 1'b0;
    serve(word);
    e.word    = word;
    e.op      = word[11:9];
    e.pc      = exp_addr;
    e.ea      = model_ea(word, exp_addr);
    e.lat     = RDL + 1;
    e.req_cyc = rc;
    if (word[11:9] < 3'd6 && word[8]) begin
      wait_req(a, rc2);
      check("ind_addr", a, e.ea);
      check("ind_req_gap", rc2, rc + RDL + 1);
      serve(ptr_data);
      e.ea  = ptr_data;
      e.lat = 2 * RDL + 2;
    end
    sb.push_back(e);
  endtask

  task automatic dispatch(input int stall, input bit noise, input bit pc_load,
                          input logic [11:0] new_pc, input bit halt);
    bit ok = 1'b0;
    int vc = 0;
    int bad = 0;
    exp_t e;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.instr_valid) begin
        ok = 1'b1;
        vc = cyc;
        break;
      end
    end
    check("valid_seen", ok, 1);
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    check("instr_word", bus.instr_word, e.word);
    check("instr_opcode", bus.instr_opcode, e.op);
    check("instr_ea", bus.instr_ea, e.ea);
    check("instr_pc", bus.instr_pc, e.pc);
    check("valid_latency", vc - e.req_cyc, e.lat);
    for (int i = 0; i < stall; i++) begin
      if (noise) begin
        bus.exec_pc_load = 1'b1;
        bus.exec_halt    = 1'b1;
        bus.exec_new_pc  = 12'o0777;
      end
      @(negedge clk);
      if (!bus.instr_valid || bus.ifu_rd_req || bus.instr_word !== e.word ||
          bus.instr_ea !== e.ea || bus.instr_pc !== e.pc || bus.instr_opcode !== e.op)
        bad++;
    end
    if (stall > 0) check("stall_stable", bad, 0);
    bus.exec_ready   = 1'b1;
    bus.exec_pc_load = pc_load;
    bus.exec_new_pc  = new_pc;
    bus.exec_halt    = halt;
    follow_cyc       = cyc;
    chk_follow       = !halt;
    @(posedge clk);
    #1;
    bus.exec_ready   = 1'b0;
    bus.exec_pc_load = 1'b0;
    bus.exec_new_pc  = 12'o0;
    bus.exec_halt    = 1'b0;
    check("valid_drop", bus.instr_valid, 0);
  endtask

  task automatic pulse_start();
    bus.start  = 1'b1;
    follow_cyc = cyc;
    chk_follow = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] a;
    int rc, bad;
    bus.start        = 1'b0;
    bus.ifu_rd_data  = 12'o0;
    bus.exec_ready   = 1'b0;
    bus.exec_pc_load = 1'b0;
    bus.exec_new_pc  = 12'o0;
    bus.exec_halt    = 1'b0;

    #1 rst = 1'b1;
    #10 check("reset_outputs", all_outs(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_without_start", all_outs(), 0);

    pulse_start();
    fetch_instr(12'o0200, 12'o7200, 12'o0);
    dispatch(0, 0, 0, 12'o0, 0);
    fetch_instr(12'o0201, 12'o5234, 12'o0);
    dispatch(0, 0, 1, 12'o1234, 0);
    fetch_instr(12'o1234, 12'o1277, 12'o0);
    dispatch(0, 0, 1, 12'o1234, 0);
    fetch_instr(12'o1234, 12'o1077, 12'o0);
    dispatch(5, 1, 0, 12'o0, 0);
    fetch_instr(12'o1235, 12'o7000, 12'o0);
    dispatch(0, 0, 1, 12'o0200, 0);
    fetch_instr(12'o0200, 12'o1410, 12'o3000);
    dispatch(0, 0, 1, 12'o0400, 0);
    fetch_instr(12'o0400, 12'o6777, 12'o0);
    dispatch(2, 0, 1, 12'o7777, 0);
    fetch_instr(12'o7777, 12'o2577, 12'o0123);
    dispatch(0, 0, 0, 12'o0, 0);
    fetch_instr(12'o0000, 12'o3017, 12'o0);
    dispatch(0, 0, 1, 12'o0555, 1);

    check("halt_busy", bus.fetch_busy, 0);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.ifu_rd_req || bus.fetch_busy || bus.instr_valid) bad++;
    end
    check("halt_quiet", bad, 0);

    pulse_start();
    chk_follow = 1'b0;
    wait_req(a, rc);
    check("restart_addr", a, 12'o0200);
    check("restart_follows", rc, follow_cyc + 1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("reset_mid_wait", all_outs(), 0);
    bus.ifu_rd_data = 12'o7402;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.ifu_rd_req || bus.fetch_busy || bus.instr_valid) bad++;
    end
    check("post_reset_quiet", bad, 0);

    pulse_start();
    fetch_instr(12'o0200, 12'o7402, 12'o0);
    dispatch(0, 0, 0, 12'o0, 1);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
